// File: rtl/moldudp64_pkg.sv
// Shared constants for the MoldUDP64 header tracker: header layout,
// special message counts, classification codes and the parser state type.
package moldudp64_pkg;

  localparam int HDR_LEN  = 20;
  localparam int SESS_OFF = 0;
  localparam int SEQ_OFF  = 10;
  localparam int CNT_OFF  = 18;

  localparam logic [15:0] HEARTBEAT_CNT   = 16'h0000;
  localparam logic [15:0] END_SESSION_CNT = 16'hFFFF;

  localparam logic [2:0] KIND_IN_ORDER    = 3'd0;
  localparam logic [2:0] KIND_GAP         = 3'd1;
  localparam logic [2:0] KIND_DUP         = 3'd2;
  localparam logic [2:0] KIND_OVERLAP     = 3'd3;
  localparam logic [2:0] KIND_HEARTBEAT   = 3'd4;
  localparam logic [2:0] KIND_END_SESSION = 3'd5;
  localparam logic [2:0] KIND_RESYNC      = 3'd6;

  typedef enum logic {
    ST_HDR     = 1'b0,
    ST_PAYLOAD = 1'b1
  } hdr_state_e;

endpackage

// File: rtl/moldudp64_seq_tracker.sv
// Classifies each captured MoldUDP64 header against the locked session's
// expected sequence number and registers the result as a one-cycle report.
module moldudp64_seq_tracker
  import moldudp64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_done_i,
  input  logic [79:0] session_i,
  input  logic [63:0] seq_i,
  input  logic [15:0] cnt_i,
  output logic        hdr_valid_o,
  output logic [79:0] session_id_o,
  output logic [63:0] seq_num_o,
  output logic [15:0] msg_count_o,
  output logic [2:0]  kind_o,
  output logic [63:0] gap_len_o,
  output logic [63:0] expected_seq_o,
  output logic        dbg_locked_o
);

  logic        locked_q, locked_d;
  logic [79:0] lock_sess_q, lock_sess_d;
  logic [63:0] exp_q, exp_d;

  logic        hdr_valid_q, hdr_valid_d;
  logic [79:0] session_q, session_d;
  logic [63:0] seq_q, seq_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  kind_q, kind_d;
  logic [63:0] gap_q, gap_d;
  logic [63:0] exp_out_q, exp_out_d;

  logic [63:0] seq_end;

  // Sums wrap modulo 2^64 and all orderings are plain unsigned compares.
  assign seq_end = seq_i + {48'd0, cnt_i};

  always_comb begin
    locked_d    = locked_q;
    lock_sess_d = lock_sess_q;
    exp_d       = exp_q;
    hdr_valid_d = hdr_done_i;
    session_d   = session_q;
    seq_d       = seq_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
    gap_d       = gap_q;
    if (hdr_done_i) begin
      session_d = session_i;
      seq_d     = seq_i;
      cnt_d     = cnt_i;
      gap_d     = '0;
      if (!locked_q || (session_i != lock_sess_q)) begin
        kind_d      = KIND_RESYNC;
        locked_d    = 1'b1;
        lock_sess_d = session_i;
        exp_d       = seq_end;
      end else if (cnt_i == END_SESSION_CNT) begin
        kind_d   = KIND_END_SESSION;
        locked_d = 1'b0;
      end else if (cnt_i == HEARTBEAT_CNT) begin
        if (seq_i > exp_q) begin
          kind_d = KIND_GAP;
          gap_d  = seq_i - exp_q;
          exp_d  = seq_i;
        end else begin
          kind_d = KIND_HEARTBEAT;
        end
      end else if (seq_i == exp_q) begin
        kind_d = KIND_IN_ORDER;
        exp_d  = seq_end;
      end else if (seq_i > exp_q) begin
        kind_d = KIND_GAP;
        gap_d  = seq_i - exp_q;
        exp_d  = seq_end;
      end else if (seq_end <= exp_q) begin
        kind_d = KIND_DUP;
      end else begin
        kind_d = KIND_OVERLAP;
        exp_d  = seq_end;
      end
    end
  end

  assign exp_out_d = hdr_done_i ? exp_d : exp_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q    <= 1'b0;
      lock_sess_q <= '0;
      exp_q       <= '0;
      hdr_valid_q <= 1'b0;
      session_q   <= '0;
      seq_q       <= '0;
      cnt_q       <= '0;
      kind_q      <= KIND_IN_ORDER;
      gap_q       <= '0;
      exp_out_q   <= '0;
    end else begin
      locked_q    <= locked_d;
      lock_sess_q <= lock_sess_d;
      exp_q       <= exp_d;
      hdr_valid_q <= hdr_valid_d;
      session_q   <= session_d;
      seq_q       <= seq_d;
      cnt_q       <= cnt_d;
      kind_q      <= kind_d;
      gap_q       <= gap_d;
      exp_out_q   <= exp_out_d;
    end
  end

  assign hdr_valid_o    = hdr_valid_q;
  assign session_id_o   = session_q;
  assign seq_num_o      = seq_q;
  assign msg_count_o    = cnt_q;
  assign kind_o         = kind_q;
  assign gap_len_o      = gap_q;
  assign expected_seq_o = exp_out_q;
  assign dbg_locked_o   = locked_q;

endmodule

// File: rtl/moldudp64_header_tracker.sv
// MoldUDP64 header extractor: counts packet bytes, captures the 20-byte header
// at HDR_OFFSET from any lane alignment and hands it to the sequence tracker.
module moldudp64_header_tracker
  import moldudp64_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int HDR_OFFSET = 42
) (
  input  logic                    clk,
  input  logic                    rst,
  // Stream handshake: a beat transfers on every cycle in_valid_i is high;
  // there is no ready, so every valid beat is consumed unconditionally.
  input  logic                    in_valid_i,
  input  logic [8*DATA_BYTES-1:0] in_data_i,
  input  logic [DATA_BYTES-1:0]   in_keep_i,
  input  logic                    in_last_i,
  output logic                    hdr_valid_o,
  output logic [79:0]             session_id_o,
  output logic [63:0]             seq_num_o,
  output logic [15:0]             msg_count_o,
  output logic [2:0]              kind_o,
  output logic [63:0]             gap_len_o,
  output logic [63:0]             expected_seq_o,
  output logic                    err_short_o,
  output logic                    dbg_state_o,
  output logic                    dbg_locked_o
);

  localparam int POS_MAX = HDR_OFFSET + HDR_LEN;
  localparam int POS_W   = $clog2(POS_MAX + DATA_BYTES + 1);

  hdr_state_e             state_q, state_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [8*HDR_LEN-1:0]   hdr_q, hdr_d;
  logic                   hdr_done_q, hdr_done_d;
  logic                   err_short_q, err_short_d;

  logic [POS_W-1:0]       beat_cnt;
  logic [POS_W-1:0]       pos_sum;
  logic                   hdr_complete;

  logic [79:0]            cap_session;
  logic [63:0]            cap_seq;
  logic [15:0]            cap_cnt;

  // Keep is contiguous from lane 0, so its popcount is the beat length.
  always_comb begin
    beat_cnt = '0;
    for (int l = 0; l < DATA_BYTES; l++) begin
      beat_cnt = beat_cnt + POS_W'(in_keep_i[l]);
    end
  end

  assign pos_sum      = pos_q + beat_cnt;
  assign hdr_complete = (state_q == ST_HDR) && (pos_sum >= POS_W'(POS_MAX));

  // Header byte h comes from lane l when pos_q + l == HDR_OFFSET + h.
  always_comb begin
    hdr_d = hdr_q;
    if (in_valid_i && (state_q == ST_HDR)) begin
      for (int h = 0; h < HDR_LEN; h++) begin
        for (int l = 0; l < DATA_BYTES; l++) begin
          if ((HDR_OFFSET + h - l >= 0) && (HDR_OFFSET + h - l < POS_MAX)) begin
            if (in_keep_i[l] && (pos_q == POS_W'(HDR_OFFSET + h - l))) begin
              hdr_d[8*h +: 8] = in_data_i[8*l +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    hdr_done_d  = 1'b0;
    err_short_d = 1'b0;
    if (in_valid_i) begin
      pos_d = (pos_sum >= POS_W'(POS_MAX)) ? POS_W'(POS_MAX) : pos_sum;
      unique case (state_q)
        ST_HDR: begin
          if (hdr_complete) begin
            hdr_done_d = 1'b1;
            if (!in_last_i) state_d = ST_PAYLOAD;
          end else if (in_last_i) begin
            err_short_d = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (in_last_i) state_d = ST_HDR;
        end
        default: state_d = ST_HDR;
      endcase
      if (in_last_i) pos_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HDR;
      pos_q       <= '0;
      hdr_q       <= '0;
      hdr_done_q  <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      hdr_q       <= hdr_d;
      hdr_done_q  <= hdr_done_d;
      err_short_q <= err_short_d;
    end
  end

  // Wire byte order is big-endian: the first header byte is the field MSB.
  always_comb begin
    cap_session = '0;
    cap_seq     = '0;
    cap_cnt     = '0;
    for (int i = 0; i < 10; i++) begin
      cap_session[8*(9-i) +: 8] = hdr_q[8*(SESS_OFF+i) +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      cap_seq[8*(7-i) +: 8] = hdr_q[8*(SEQ_OFF+i) +: 8];
    end
    for (int i = 0; i < 2; i++) begin
      cap_cnt[8*(1-i) +: 8] = hdr_q[8*(CNT_OFF+i) +: 8];
    end
  end

  moldudp64_seq_tracker u_tracker (
    .clk            (clk),
    .rst            (rst),
    .hdr_done_i     (hdr_done_q),
    .session_i      (cap_session),
    .seq_i          (cap_seq),
    .cnt_i          (cap_cnt),
    .hdr_valid_o    (hdr_valid_o),
    .session_id_o   (session_id_o),
    .seq_num_o      (seq_num_o),
    .msg_count_o    (msg_count_o),
    .kind_o         (kind_o),
    .gap_len_o      (gap_len_o),
    .expected_seq_o (expected_seq_o),
    .dbg_locked_o   (dbg_locked_o)
  );

  assign err_short_o = err_short_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_moldudp64_header_tracker.sv
// Directed bench: an 8-byte-lane instance for classification and short-packet
// cases, a 64-byte-lane instance for single-beat back-to-back and reset cases.
module tb_moldudp64_header_tracker;

  localparam logic [2:0] K_IN_ORDER = 3'd0;
  localparam logic [2:0] K_GAP      = 3'd1;
  localparam logic [2:0] K_DUP      = 3'd2;
  localparam logic [2:0] K_OVERLAP  = 3'd3;
  localparam logic [2:0] K_HB       = 3'd4;
  localparam logic [2:0] K_END      = 3'd5;
  localparam logic [2:0] K_RESYNC   = 3'd6;

  localparam logic [79:0] SESS_A = 80'h4142_4344_4546_4748_494A; // "ABCDEFGHIJ"
  localparam logic [79:0] SESS_B = 80'h5A5A_0102_0304_0506_0708;

  int vectors    = 0;
  int miscompares = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst64 = 1'b1;
  always #5 clk = ~clk;

  // 8-lane instance
  logic        v8 = 1'b0, l8 = 1'b0;
  logic [63:0] d8 = '0;
  logic [7:0]  k8 = '0;
  logic        hv8, es8, st8, lk8;
  logic [79:0] sess8;
  logic [63:0] seq8, gap8, exp8;
  logic [15:0] cnt8;
  logic [2:0]  kind8;

  moldudp64_header_tracker #(.DATA_BYTES(8), .HDR_OFFSET(42)) dut8 (
    .clk(clk), .rst(rst8), .in_valid_i(v8), .in_data_i(d8), .in_keep_i(k8),
    .in_last_i(l8), .hdr_valid_o(hv8), .session_id_o(sess8), .seq_num_o(seq8),
    .msg_count_o(cnt8), .kind_o(kind8), .gap_len_o(gap8), .expected_seq_o(exp8),
    .err_short_o(es8), .dbg_state_o(st8), .dbg_locked_o(lk8)
  );

  // 64-lane instance
  logic         v64 = 1'b0, l64 = 1'b0;
  logic [511:0] d64 = '0;
  logic [63:0]  k64 = '0;
  logic         hv64, es64, st64, lk64;
  logic [79:0]  sess64;
  logic [63:0]  seq64, gap64, exp64;
  logic [15:0]  cnt64;
  logic [2:0]   kind64;

  moldudp64_header_tracker #(.DATA_BYTES(64), .HDR_OFFSET(42)) dut64 (
    .clk(clk), .rst(rst64), .in_valid_i(v64), .in_data_i(d64), .in_keep_i(k64),
    .in_last_i(l64), .hdr_valid_o(hv64), .session_id_o(sess64), .seq_num_o(seq64),
    .msg_count_o(cnt64), .kind_o(kind64), .gap_len_o(gap64), .expected_seq_o(exp64),
    .err_short_o(es64), .dbg_state_o(st64), .dbg_locked_o(lk64)
  );

  // packet byte i: header at 42..61, filler elsewhere
  function automatic logic [7:0] pkt_byte(input logic [79:0] s, input logic [63:0] q,
                                          input logic [15:0] c, input int i);
    logic [79:0] ts;
    logic [63:0] tq;
    logic [15:0] tc;
    int h;
    h = i - 42;
    if (h < 0 || h >= 20) return 8'(i) ^ 8'hA5;
    ts = s >> (8 * (9 - h));
    tq = q >> (8 * (17 - h));
    tc = c >> (8 * (19 - h));
    if (h < 10) return ts[7:0];
    if (h < 18) return tq[7:0];
    return tc[7:0];
  endfunction

  // driver tasks
  task automatic send_pkt8(input logic [79:0] s, input logic [63:0] q,
                           input logic [15:0] c, input int nbytes);
    int nbeats;
    nbeats = (nbytes + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      @(posedge clk); #1;
      v8 = 1'b1;
      l8 = (b == nbeats - 1);
      for (int n = 0; n < 8; n++) begin
        d8[8*n +: 8] = (b*8 + n < nbytes) ? pkt_byte(s, q, c, b*8 + n) : 8'h00;
        k8[n]        = (b*8 + n < nbytes);
      end
    end
    @(posedge clk); #1;
    v8 = 1'b0; l8 = 1'b0; k8 = '0; d8 = '0;
  endtask

  task automatic drive_beat64(input logic [79:0] s, input logic [63:0] q,
                              input logic [15:0] c, input int nbytes, input logic last);
    v64 = 1'b1;
    l64 = last;
    for (int n = 0; n < 64; n++) begin
      d64[8*n +: 8] = (n < nbytes) ? pkt_byte(s, q, c, n) : 8'h00;
      k64[n]        = (n < nbytes);
    end
  endtask

  task automatic idle64();
    v64 = 1'b0; l64 = 1'b0; k64 = '0; d64 = '0;
  endtask

  task automatic wait_hdr8(input string tag);
    int n;
    n = 0;
    while (hv8 !== 1'b1 && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (hv8 !== 1'b1) begin miscompares++; $display("FAIL %s hdr_valid got %b want 1 (timeout)", tag, hv8); end
  endtask

  // tests
  task automatic test_reset();
    vectors++; if (hv8 !== 1'b0) begin miscompares++; $display("FAIL rst_hv8 got %b want 0", hv8); end
    vectors++; if (es8 !== 1'b0) begin miscompares++; $display("FAIL rst_es8 got %b want 0", es8); end
    vectors++; if (kind8 !== K_IN_ORDER) begin miscompares++; $display("FAIL rst_kind8 got %0d want 0", kind8); end
    vectors++; if (exp8 !== 64'd0) begin miscompares++; $display("FAIL rst_exp8 got %0d want 0", exp8); end
    vectors++; if (sess8 !== 80'd0) begin miscompares++; $display("FAIL rst_sess8 got %h want 0", sess8); end
    vectors++; if (hv64 !== 1'b0) begin miscompares++; $display("FAIL rst_hv64 got %b want 0", hv64); end
    vectors++; if (seq64 !== 64'd0) begin miscompares++; $display("FAIL rst_seq64 got %0d want 0", seq64); end
  endtask

  task automatic test_resync();
    send_pkt8(SESS_A, 64'd1, 16'd3, 64);
    // completing beat sampled one edge ago: hdr_done stage only
    vectors++; if (hv8 !== 1'b0) begin miscompares++; $display("FAIL resync_early got %b want 0", hv8); end
    @(posedge clk); #1;
    vectors++; if (hv8 !== 1'b1) begin miscompares++; $display("FAIL resync_latency got %b want 1", hv8); end
    vectors++; if (sess8 !== SESS_A) begin miscompares++; $display("FAIL resync_sess got %h want %h", sess8, SESS_A); end
    vectors++; if (seq8 !== 64'd1) begin miscompares++; $display("FAIL resync_seq got %0d want 1", seq8); end
    vectors++; if (cnt8 !== 16'd3) begin miscompares++; $display("FAIL resync_cnt got %0d want 3", cnt8); end
    vectors++; if (kind8 !== K_RESYNC) begin miscompares++; $display("FAIL resync_kind got %0d want %0d", kind8, K_RESYNC); end
    vectors++; if (exp8 !== 64'd4) begin miscompares++; $display("FAIL resync_exp got %0d want 4", exp8); end
  endtask

  task automatic test_in_order_gap();
    send_pkt8(SESS_A, 64'd4, 16'd2, 64);
    wait_hdr8("in_order");
    vectors++; if (kind8 !== K_IN_ORDER) begin miscompares++; $display("FAIL in_order_kind got %0d want %0d", kind8, K_IN_ORDER); end
    vectors++; if (exp8 !== 64'd6) begin miscompares++; $display("FAIL in_order_exp got %0d want 6", exp8); end
    send_pkt8(SESS_A, 64'd10, 16'd1, 64);
    wait_hdr8("gap");
    vectors++; if (kind8 !== K_GAP) begin miscompares++; $display("FAIL gap_kind got %0d want %0d", kind8, K_GAP); end
    vectors++; if (gap8 !== 64'd4) begin miscompares++; $display("FAIL gap_len got %0d want 4", gap8); end
    vectors++; if (exp8 !== 64'd11) begin miscompares++; $display("FAIL gap_exp got %0d want 11", exp8); end
    @(posedge clk); #1;
    vectors++; if (hv8 !== 1'b0) begin miscompares++; $display("FAIL gap_pulse got %b want 0", hv8); end
    vectors++; if (gap8 !== 64'd4) begin miscompares++; $display("FAIL gap_hold got %0d want 4", gap8); end
  endtask

  task automatic test_dup_overlap();
    send_pkt8(SESS_A, 64'd5, 16'd3, 64);
    wait_hdr8("dup");
    vectors++; if (kind8 !== K_DUP) begin miscompares++; $display("FAIL dup_kind got %0d want %0d", kind8, K_DUP); end
    vectors++; if (exp8 !== 64'd11) begin miscompares++; $display("FAIL dup_exp got %0d want 11", exp8); end
    vectors++; if (gap8 !== 64'd0) begin miscompares++; $display("FAIL dup_gap got %0d want 0", gap8); end
    send_pkt8(SESS_A, 64'd9, 16'd5, 64);
    wait_hdr8("overlap");
    vectors++; if (kind8 !== K_OVERLAP) begin miscompares++; $display("FAIL overlap_kind got %0d want %0d", kind8, K_OVERLAP); end
    vectors++; if (exp8 !== 64'd14) begin miscompares++; $display("FAIL overlap_exp got %0d want 14", exp8); end
  endtask

  task automatic test_heartbeat_end();
    send_pkt8(SESS_A, 64'd14, 16'h0000, 64);
    wait_hdr8("heartbeat");
    vectors++; if (kind8 !== K_HB) begin miscompares++; $display("FAIL hb_kind got %0d want %0d", kind8, K_HB); end
    vectors++; if (exp8 !== 64'd14) begin miscompares++; $display("FAIL hb_exp got %0d want 14", exp8); end
    send_pkt8(SESS_A, 64'd14, 16'hFFFF, 64);
    wait_hdr8("end_session");
    vectors++; if (kind8 !== K_END) begin miscompares++; $display("FAIL end_kind got %0d want %0d", kind8, K_END); end
    vectors++; if (cnt8 !== 16'hFFFF) begin miscompares++; $display("FAIL end_cnt got %h want ffff", cnt8); end
    send_pkt8(SESS_A, 64'd100, 16'd2, 64);
    wait_hdr8("post_end");
    vectors++; if (kind8 !== K_RESYNC) begin miscompares++; $display("FAIL post_end_kind got %0d want %0d", kind8, K_RESYNC); end
    vectors++; if (exp8 !== 64'd102) begin miscompares++; $display("FAIL post_end_exp got %0d want 102", exp8); end
    send_pkt8(SESS_A, 64'd110, 16'h0000, 64);
    wait_hdr8("hb_gap");
    vectors++; if (kind8 !== K_GAP) begin miscompares++; $display("FAIL hb_gap_kind got %0d want %0d", kind8, K_GAP); end
    vectors++; if (gap8 !== 64'd8) begin miscompares++; $display("FAIL hb_gap_len got %0d want 8", gap8); end
    vectors++; if (exp8 !== 64'd110) begin miscompares++; $display("FAIL hb_gap_exp got %0d want 110", exp8); end
  endtask

  task automatic test_short();
    int seen;
    send_pkt8(SESS_A, 64'd999, 16'd7, 48);
    vectors++; if (es8 !== 1'b1) begin miscompares++; $display("FAIL short_err got %b want 1", es8); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (hv8 === 1'b1) seen++;
      @(posedge clk); #1;
    end
    vectors++; if (es8 !== 1'b0) begin miscompares++; $display("FAIL short_err_pulse got %b want 0", es8); end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL short_no_hdr got %0d hdr_valid cycles want 0", seen); end
    send_pkt8(SESS_A, 64'd110, 16'd4, 64);
    wait_hdr8("after_short");
    vectors++; if (kind8 !== K_IN_ORDER) begin miscompares++; $display("FAIL after_short_kind got %0d want %0d", kind8, K_IN_ORDER); end
    vectors++; if (seq8 !== 64'd110) begin miscompares++; $display("FAIL after_short_seq got %0d want 110", seq8); end
    vectors++; if (exp8 !== 64'd114) begin miscompares++; $display("FAIL after_short_exp got %0d want 114", exp8); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] seq_t [4];
    logic [15:0] cnt_t [4];
    logic [2:0]  kind_t[4];
    logic [63:0] exp_t [4];
    logic [63:0] gap_t [4];
    seq_t  = '{64'd1000, 64'd1005, 64'd1010, 64'd1011};
    cnt_t  = '{16'd5, 16'd3, 16'd1, 16'd4};
    kind_t = '{K_RESYNC, K_IN_ORDER, K_GAP, K_IN_ORDER};
    exp_t  = '{64'd1005, 64'd1008, 64'd1011, 64'd1015};
    gap_t  = '{64'd0, 64'd0, 64'd2, 64'd0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i >= 2) begin
        vectors++; if (hv64 !== 1'b1) begin miscompares++; $display("FAIL b2b_hv[%0d] got %b want 1", i-2, hv64); end
        vectors++; if (seq64 !== seq_t[i-2]) begin miscompares++; $display("FAIL b2b_seq[%0d] got %0d want %0d", i-2, seq64, seq_t[i-2]); end
        vectors++; if (kind64 !== kind_t[i-2]) begin miscompares++; $display("FAIL b2b_kind[%0d] got %0d want %0d", i-2, kind64, kind_t[i-2]); end
        vectors++; if (exp64 !== exp_t[i-2]) begin miscompares++; $display("FAIL b2b_exp[%0d] got %0d want %0d", i-2, exp64, exp_t[i-2]); end
        vectors++; if (gap64 !== gap_t[i-2]) begin miscompares++; $display("FAIL b2b_gap[%0d] got %0d want %0d", i-2, gap64, gap_t[i-2]); end
      end
      if (i < 4) drive_beat64(SESS_B, seq_t[i], cnt_t[i], 62, 1'b1);
      else idle64();
    end
    @(posedge clk); #1;
    vectors++; if (hv64 !== 1'b0) begin miscompares++; $display("FAIL b2b_end got %b want 0", hv64); end
  endtask

  task automatic test_reset_midstream();
    drive_beat64(SESS_B, 64'd1015, 16'd2, 64, 1'b0);
    @(posedge clk); #1;
    idle64();
    rst64 = 1'b1;
    @(posedge clk); #1;
    vectors++; if (hv64 !== 1'b0) begin miscompares++; $display("FAIL mrst_hv got %b want 0", hv64); end
    vectors++; if (kind64 !== K_IN_ORDER) begin miscompares++; $display("FAIL mrst_kind got %0d want 0", kind64); end
    vectors++; if (exp64 !== 64'd0) begin miscompares++; $display("FAIL mrst_exp got %0d want 0", exp64); end
    vectors++; if (sess64 !== 80'd0) begin miscompares++; $display("FAIL mrst_sess got %h want 0", sess64); end
    vectors++; if (cnt64 !== 16'd0) begin miscompares++; $display("FAIL mrst_cnt got %0d want 0", cnt64); end
    rst64 = 1'b0;
    drive_beat64(SESS_B, 64'd1015, 16'd2, 62, 1'b1);
    @(posedge clk); #1;
    idle64();
    vectors++; if (hv64 !== 1'b0) begin miscompares++; $display("FAIL mrst_stale got %b want 0", hv64); end
    @(posedge clk); #1;
    vectors++; if (hv64 !== 1'b1) begin miscompares++; $display("FAIL mrst_next_hv got %b want 1", hv64); end
    vectors++; if (kind64 !== K_RESYNC) begin miscompares++; $display("FAIL mrst_next_kind got %0d want %0d", kind64, K_RESYNC); end
    vectors++; if (exp64 !== 64'd1017) begin miscompares++; $display("FAIL mrst_next_exp got %0d want 1017", exp64); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b0;
    rst64 = 1'b0;
    test_reset();
    test_resync();
    test_in_order_gap();
    test_dup_overlap();
    test_heartbeat_end();
    test_short();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
